instruction_loader: RTL and testbench

- Writer side of the instruction memory. Accepts a byte stream from a host/boot link and assembles little-endian 32-bit instruction words.
- Issues one write per word into the instruction memory, at byte addresses 0, 4, 8, …, matching PC/4 word indexing.
- Holds the CPU (cpu_hold) while loading and flags completion or error.

---
 rtl/instruction_loader.sv | 157 +++++++++++++++
 tb/tb_instruction_loader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_loader.sv
`timescale 1ns/1ps
// Purpose: assembles a length-prefixed little-endian byte stream into 32-bit instruction-memory writes.
// Latency: the write strobe is issued 1 cycle after the 4th byte of a word is accepted.
// Backpressure: byte_ready drops during WRITE and outside a load; byte_valid may gap for any number of cycles.
//
// Ports: clock/reset (async active-low); start begins a load from IDLE/DONE/ERROR;
//        byte_in/byte_valid/byte_ready form the stream handshake; wr_en/wr_addr/wr_data
//        drive the instruction memory; cpu_hold, done, error and word_count report status.
// Optional: define INSTRUCTION_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module instruction_loader #(
  parameter int DEPTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  output logic             byte_ready,
  output logic             wr_en,
  output logic [31:0]      wr_addr,
  output logic [31:0]      wr_data,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] word_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_COLLECT,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  localparam logic [8:0] DEPTH_L = 9'(DEPTH);

  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] len_n;
  logic [CNT_W-1:0] cnt_inc;
  logic [1:0]       idx;
  logic [23:0]      lanes;     // bytes 0..2 of the word; byte 3 goes straight to wr_data
  logic             accept;
  logic             start_ok;

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign accept   = byte_valid && byte_ready;
  assign start_ok = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign cnt_inc  = word_count + CNT_W'(1);

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) next_state = S_LEN;
      end
      S_LEN: begin
        if (accept) begin
          if (byte_in == 8'd0 || {1'b0, byte_in} > DEPTH_L) next_state = S_ERROR;
          else                                              next_state = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (accept && idx == 2'd3) next_state = S_WRITE;
      end
      S_WRITE: begin
        if (cnt_inc == len_n) begin
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
          next_state = S_CHECK;
`else
          next_state = S_DONE;
`endif
        end else begin
          next_state = S_COLLECT;
        end
      end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (accept) next_state = (byte_in == csum) ? S_DONE : S_ERROR;
      end
`endif
      default: next_state = S_IDLE;
    endcase
  end

  // Status outputs are registered from next_state so they line up with the state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      byte_ready <= 1'b0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      wr_en      <= 1'b0;
      wr_addr    <= 32'd0;
      wr_data    <= 32'd0;
      word_count <= '0;
      len_n      <= '0;
      idx        <= 2'd0;
      lanes      <= 24'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
      csum       <= 8'd0;
`endif
    end else begin
      state      <= next_state;
      byte_ready <= (next_state == S_LEN) || (next_state == S_COLLECT) || (next_state == S_CHECK);
      cpu_hold   <= (next_state == S_LEN) || (next_state == S_COLLECT) || (next_state == S_WRITE) ||
                    (next_state == S_CHECK) || (next_state == S_ERROR);
      done       <= (next_state == S_DONE);
      error      <= (next_state == S_ERROR);
      wr_en      <= (next_state == S_WRITE);

      if (start_ok) begin
        word_count <= '0;
        len_n      <= '0;
        idx        <= 2'd0;
        lanes      <= 24'd0;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum       <= 8'd0;
`endif
      end

      if (state == S_LEN && accept) begin
        len_n <= CNT_W'(byte_in);
      end

      if (state == S_COLLECT && accept) begin
        case (idx)
          2'd0:    lanes[7:0]   <= byte_in;
          2'd1:    lanes[15:8]  <= byte_in;
          2'd2:    lanes[23:16] <= byte_in;
          default: begin
            // Capture the word and its address now so WRITE can present them immediately.
            wr_data <= {byte_in, lanes};
            wr_addr <= 32'({word_count, 2'b00});
          end
        endcase
        idx <= idx + 2'd1;
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
        csum <= csum ^ byte_in;
`endif
      end

      if (state == S_WRITE) begin
        word_count <= cnt_inc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
`timescale 1ns/1ps
module tb_instruction_loader;

  localparam int DEPTH = 32;
  localparam int CNT_W = 6;

  logic             clock = 1'b0;
  logic             reset;
  logic             start;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             byte_ready;
  logic             wr_en;
  logic [31:0]      wr_addr;
  logic [31:0]      wr_data;
  logic             cpu_hold;
  logic             done;
  logic             error;
  logic [CNT_W-1:0] word_count;

  always #5 clock = ~clock;

  instruction_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t        wq[$];          // writes seen on the memory port
  int         ready_in_write; // cycles where wr_en and byte_ready were both high
  logic [7:0] img[$];         // data bytes of the image being loaded
  int         checks = 0;
  int         errors = 0;

  always @(negedge clock) begin
    if (wr_en) begin
      wr_t w;
      w.addr = wr_addr;
      w.data = wr_data;
      wq.push_back(w);
      if (byte_ready) ready_in_write++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  // Offers one byte and returns just after the edge on which it was taken.
  task automatic send_byte(input logic [7:0] b);
    int   n;
    logic ok;
    n = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    do begin
      ok = byte_ready;
      cycle();
      n++;
    end while (!ok && n < 64);
    chk("handshake", 32'(ok), 32'd1);
  endtask

  task automatic wait_end();
    int k;
    k = 0;
    while (!(done || error) && k < 300) begin
      cycle();
      k++;
    end
    chk("end_timeout", 32'(done | error), 32'd1);
  endtask

  task automatic fill_random(input int n);
    img.delete();
    repeat (4 * n) img.push_back(8'($urandom));
  endtask

  function automatic logic [7:0] img_xor();
    logic [7:0] x;
    x = 8'd0;
    foreach (img[i]) x ^= img[i];
    return x;
  endfunction

  function automatic logic [31:0] exp_word(input int i);
    return {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
  endfunction

  // Loads img; optional random gaps, a start pulse at byte start_at, and a corrupted checksum.
  task automatic run_load(input bit do_start, input int max_gap, input int start_at,
                          input bit bad_csum, input string tag);
    int n;
    int g;
    n = img.size() / 4;
    wq.delete();
    ready_in_write = 0;
    if (do_start) pulse_start();
    chk({tag, "_len_ready"}, 32'(byte_ready), 32'd1);
    send_byte(8'(n));
    for (int i = 0; i < img.size(); i++) begin
      if (i == start_at) begin
        byte_valid = 1'b0;
        pulse_start();
        chk({tag, "_midstart_hold"}, 32'(cpu_hold), 32'd1);
        chk({tag, "_midstart_done"}, 32'(done), 32'd0);
      end
      g = (max_gap > 0) ? int'($urandom_range(max_gap)) : 0;
      if (g > 0) begin
        byte_valid = 1'b0;
        repeat (g) cycle();
      end
      send_byte(img[i]);
    end
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    send_byte(bad_csum ? (img_xor() ^ 8'h5A) : img_xor());
`endif
    byte_valid = 1'b0;
    wait_end();
    chk({tag, "_done"},  32'(done),       32'(!bad_csum));
    chk({tag, "_error"}, 32'(error),      32'(bad_csum));
    chk({tag, "_hold"},  32'(cpu_hold),   32'(bad_csum));
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_count"}, 32'(word_count), 32'(n));
    chk({tag, "_nwr"},   32'(wq.size()),  32'(n));
    chk({tag, "_rdy_in_wr"}, 32'(ready_in_write), 32'd0);
    for (int i = 0; i < n && i < wq.size(); i++) begin
      chk({tag, "_addr"}, wq[i].addr, 32'(4 * i));
      chk({tag, "_data"}, wq[i].data, exp_word(i));
    end
  endtask

  task automatic len_err(input logic [7:0] l, input string tag);
    wq.delete();
    pulse_start();
    send_byte(l);
    byte_valid = 1'b0;
    repeat (3) cycle();
    chk({tag, "_error"}, 32'(error),      32'd1);
    chk({tag, "_hold"},  32'(cpu_hold),   32'd1);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_nwr"},   32'(wq.size()),  32'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    chk({tag, "_wr_en"}, 32'(wr_en),      32'd0);
    chk({tag, "_addr"},  wr_addr,         32'd0);
    chk({tag, "_data"},  wr_data,         32'd0);
    chk({tag, "_hold"},  32'(cpu_hold),   32'd0);
    chk({tag, "_done"},  32'(done),       32'd0);
    chk({tag, "_error"}, 32'(error),      32'd0);
    chk({tag, "_count"}, 32'(word_count), 32'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    ready_in_write = 0;
    #1 reset = 1'b0;
    #3;
    chk_all_zero("reset");
    #9 reset = 1'b1;
    cycle();

    // Directed two-word image with byte_valid held high throughout.
    img = '{8'h13, 8'h01, 8'h00, 8'h00, 8'hB3, 8'h80, 8'h20, 8'h00};
    run_load(1'b1, 0, -1, 1'b0, "t1");
    chk("t1_w0_const", wq[0].data, 32'h0000_0113);
    chk("t1_w1_const", wq[1].data, 32'h0020_80B3);
    chk("t1_a1_const", wq[1].addr, 32'h0000_0004);

    // Illegal lengths.
    len_err(8'd0,  "len0");
    len_err(8'd33, "len33");

    // One word with 3-cycle gaps; a byte offered during WRITE must not be taken.
    fill_random(1);
    wq.delete();
    ready_in_write = 0;
    pulse_start();
    send_byte(8'd1);
    byte_valid = 1'b0;
    repeat (3) cycle();
    for (int i = 0; i < 4; i++) begin
      send_byte(img[i]);
      if (i < 3) begin
        byte_valid = 1'b0;
        repeat (3) cycle();
      end
    end
    chk("t3_wr_en",     32'(wr_en),      32'd1);
    chk("t3_wr_ready",  32'(byte_ready), 32'd0);
    chk("t3_wr_addr",   wr_addr,         32'd0);
    chk("t3_wr_data",   wr_data,         exp_word(0));
    byte_in = img_xor();
`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    send_byte(img_xor());
`else
    cycle();
`endif
    byte_valid = 1'b0;
    wait_end();
    chk("t3_done",  32'(done),       32'd1);
    chk("t3_count", 32'(word_count), 32'd1);
    chk("t3_nwr",   32'(wq.size()),  32'd1);
    chk("t3_rdy_in_wr", 32'(ready_in_write), 32'd0);

    // Reset after two bytes of the second word of a three-word load.
    fill_random(3);
    wq.delete();
    pulse_start();
    send_byte(8'd3);
    for (int i = 0; i < 6; i++) send_byte(img[i]);
    #2;
    reset      = 1'b0;
    byte_valid = 1'b0;
    #1;
    chk_all_zero("midreset");
    chk("midreset_nwr", 32'(wq.size()), 32'd1);
    #2 reset = 1'b1;
    cycle();
    chk("midreset_idle_ready", 32'(byte_ready), 32'd0);
    fill_random(3);
    run_load(1'b1, 2, -1, 1'b0, "after_reset");

    // start pulsed mid-COLLECT is ignored.
    fill_random(2);
    run_load(1'b1, 1, 2, 1'b0, "midstart");

    // start together with byte_valid in DONE: only start acts.
    start      = 1'b1;
    byte_valid = 1'b1;
    byte_in    = 8'h01;
    cycle();
    start      = 1'b0;
    byte_valid = 1'b0;
    chk("restart_done",  32'(done),       32'd0);
    chk("restart_count", 32'(word_count), 32'd0);
    chk("restart_ready", 32'(byte_ready), 32'd1);
    fill_random(2);
    run_load(1'b0, 0, -1, 1'b0, "restart");

    // Largest legal image, then random images with random gaps.
    fill_random(DEPTH);
    run_load(1'b1, 1, -1, 1'b0, "full");
    for (int r = 0; r < 6; r++) begin
      fill_random(int'($urandom_range(DEPTH, 1)));
      run_load(1'b1, 2, -1, 1'b0, "rand");
    end

`ifdef INSTRUCTION_LOADER_CHECKSUM_EN
    fill_random(3);
    run_load(1'b1, 1, -1, 1'b1, "badcsum");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
